// File: rtl/cacheline_adaptor.sv
// Memory-side line adaptor: splits 256-bit line reads/writes into 64-bit burst
// beats and reassembles read beats into a line, one request at a time.
module cacheline_adaptor #(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 256,
  parameter int BEAT_W   = 64,
  parameter int RESP_GAP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pmem_address,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic [ADDR_W-1:0] burst_address,
  output logic              burst_read,
  output logic              burst_write,
  output logic [BEAT_W-1:0] burst_wdata,
  input  logic [BEAT_W-1:0] burst_rdata,
  input  logic              burst_resp
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GAP_W = (RESP_GAP > 1) ? $clog2(RESP_GAP) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  // state | meaning
  // IDLE  | waiting for a line request
  // RD    | issuing burst read, collecting beats
  // WR    | issuing burst write, presenting beats
  // RESP  | pmem_resp pulse
  // GAP   | requests ignored while requester retires the old request
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_RESP, S_GAP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  beat, beat_nxt, beat_inc;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic [LINE_W-1:0] line_q, line_nxt;
  logic [LINE_W-1:0] rdata_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [BEAT_W-1:0] wdata_nxt;
  logic              rd_nxt, wr_nxt, resp_nxt, last;

  assign beat_inc = beat + 1'b1;
  assign last     = (beat == CNT_W'(BEATS - 1));

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    gap_nxt   = gap_cnt;
    line_nxt  = line_q;
    rdata_nxt = pmem_rdata;
    addr_nxt  = burst_address;
    wdata_nxt = burst_wdata;
    rd_nxt    = burst_read;
    wr_nxt    = burst_write;
    resp_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pmem_write) begin
          state_nxt = S_WR;
          addr_nxt  = pmem_address & ALIGN_MASK;
          line_nxt  = pmem_wdata;
          wdata_nxt = pmem_wdata[BEAT_W-1:0];
          wr_nxt    = 1'b1;
        end else if (pmem_read) begin
          state_nxt = S_RD;
          addr_nxt  = pmem_address & ALIGN_MASK;
          rd_nxt    = 1'b1;
        end
      end
      S_RD: begin
        if (burst_resp) begin
          rdata_nxt[beat*BEAT_W +: BEAT_W] = burst_rdata;
          beat_nxt = beat_inc;
          if (last) begin
            state_nxt = S_RESP;
            rd_nxt    = 1'b0;
            resp_nxt  = 1'b1;
          end
        end
      end
      S_WR: begin
        if (burst_resp) begin
          beat_nxt = beat_inc;
          if (last) begin
            state_nxt = S_RESP;
            wr_nxt    = 1'b0;
            resp_nxt  = 1'b1;
          end else begin
            wdata_nxt = line_q[beat_inc*BEAT_W +: BEAT_W];
          end
        end
      end
      S_RESP: begin
        if (RESP_GAP > 0) begin
          state_nxt = S_GAP;
          gap_nxt   = GAP_W'(RESP_GAP - 1);
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) state_nxt = S_IDLE;
        else               gap_nxt   = gap_cnt - 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      beat          <= '0;
      gap_cnt       <= '0;
      line_q        <= '0;
      pmem_rdata    <= '0;
      pmem_resp     <= 1'b0;
      burst_address <= '0;
      burst_read    <= 1'b0;
      burst_write   <= 1'b0;
      burst_wdata   <= '0;
    end else begin
      state         <= state_nxt;
      beat          <= beat_nxt;
      gap_cnt       <= gap_nxt;
      line_q        <= line_nxt;
      pmem_rdata    <= rdata_nxt;
      pmem_resp     <= resp_nxt;
      burst_address <= addr_nxt;
      burst_read    <= rd_nxt;
      burst_write   <= wr_nxt;
      burst_wdata   <= wdata_nxt;
    end
  end

endmodule
